// File: rtl/garage_door_pkg.sv
// Shared types and default timing for the garage door actuator.
// The state encodings are 3-bit so FAULT fits alongside the four motion states.
package garage_door_pkg;

  localparam int FULL_POS_DEF  = 200;
  localparam int STEP_DIV_DEF  = 4;
  localparam int MOTOR_DLY_DEF = 2;

  typedef enum logic [2:0] {
    ST_STOPPED = 3'd0,
    ST_SPIN_UP = 3'd1,
    ST_RUN_UP  = 3'd2,
    ST_RUN_DN  = 3'd3,
    ST_FAULT   = 3'd4
  } door_state_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/door_step_timer.sv
// Step prescaler: while enabled it counts 0..STEP_DIV-1 and pulses step on
// the terminal count; clr returns it to 0.
module door_step_timer
  import garage_door_pkg::*;
#(
  parameter int STEP_DIV = STEP_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic step
);

  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(STEP_DIV - 1);

  logic [CW-1:0] cnt;

  // Prescaler counter with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= {CW{1'b0}};
    end else if (clr) begin
      cnt <= {CW{1'b0}};
    end else if (en) begin
      cnt <= (cnt == TERM) ? {CW{1'b0}} : cnt + 1'b1;
    end else begin
      cnt <= cnt;
    end
  end

  assign step = en & (cnt == TERM);

endmodule

// File: rtl/garage_door_actuator.sv
// Garage door actuator: motor spin-up, stepped travel between the limits,
// and a latched fault on conflicting up/down commands.
module garage_door_actuator
  import garage_door_pkg::*;
#(
  parameter int POS_W     = 8,
  parameter int FULL_POS  = FULL_POS_DEF,
  parameter int STEP_DIV  = STEP_DIV_DEF,
  parameter int MOTOR_DLY = MOTOR_DLY_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             UP_M,
  input  logic             DN_M,
  input  logic             fault_clr,
  output logic             UP_Max,
  output logic             DN_Max,
  output logic [POS_W-1:0] Position,
  output logic             Moving,
  output logic             Fault
);

  localparam int SCW = (MOTOR_DLY > 1) ? $clog2(MOTOR_DLY) : 1;
  localparam logic [SCW-1:0]   SPIN_TERM = SCW'(MOTOR_DLY - 1);
  localparam logic [POS_W-1:0] POS_FULL  = POS_W'(FULL_POS);
  localparam logic [POS_W-1:0] POS_ZERO  = {POS_W{1'b0}};
  localparam logic [POS_W-1:0] POS_ONE   = {{(POS_W-1){1'b0}}, 1'b1};

  door_state_t      state, state_nxt;
  logic             dir, dir_nxt;
  logic [SCW-1:0]   spin_cnt, spin_cnt_nxt;
  logic [POS_W-1:0] pos, pos_nxt;
  logic             moving, fault;
  logic             tmr_en, tmr_clr, step;
  logic             up_only, dn_only, both_cmd;
  logic             at_top, at_bot;
  logic             want, opp, opp_blocked;

  assign up_only  = UP_M & ~DN_M;
  assign dn_only  = DN_M & ~UP_M;
  assign both_cmd = UP_M & DN_M;
  assign at_top   = (pos == POS_FULL);
  assign at_bot   = (pos == POS_ZERO);
  assign want     = (dir == DIR_UP) ? up_only : dn_only;
  assign opp      = (dir == DIR_UP) ? dn_only : up_only;
  // Reversing toward a limit the door already sits on is treated as a stop.
  assign opp_blocked = (dir == DIR_UP) ? at_bot : at_top;
  assign tmr_clr  = ~tmr_en;

  door_step_timer #(
    .STEP_DIV (STEP_DIV)
  ) u_step_timer (
    .clk  (clk),
    .rst  (rst),
    .en   (tmr_en),
    .clr  (tmr_clr),
    .step (step)
  );

  // Next-state, direction, spin-up count and position update.
  always_comb begin
    state_nxt    = state;
    dir_nxt      = dir;
    spin_cnt_nxt = spin_cnt;
    pos_nxt      = pos;
    tmr_en       = 1'b0;
    if ((state != ST_FAULT) && both_cmd) begin
      state_nxt = ST_FAULT;
    end else begin
      case (state)
        ST_STOPPED: begin
          if (up_only && !at_top) begin
            state_nxt    = ST_SPIN_UP;
            dir_nxt      = DIR_UP;
            spin_cnt_nxt = {SCW{1'b0}};
          end else if (dn_only && !at_bot) begin
            state_nxt    = ST_SPIN_UP;
            dir_nxt      = DIR_DN;
            spin_cnt_nxt = {SCW{1'b0}};
          end else begin
            state_nxt = ST_STOPPED;
          end
        end
        ST_SPIN_UP: begin
          if (want) begin
            if (spin_cnt == SPIN_TERM) begin
              state_nxt    = (dir == DIR_UP) ? ST_RUN_UP : ST_RUN_DN;
              spin_cnt_nxt = {SCW{1'b0}};
            end else begin
              spin_cnt_nxt = spin_cnt + 1'b1;
            end
          end else if (opp && !opp_blocked) begin
            dir_nxt      = ~dir;
            spin_cnt_nxt = {SCW{1'b0}};
          end else begin
            state_nxt = ST_STOPPED;
          end
        end
        ST_RUN_UP, ST_RUN_DN: begin
          if (want) begin
            tmr_en = 1'b1;
            if (step && (dir == DIR_UP)) begin
              pos_nxt   = pos + POS_ONE;
              state_nxt = ((pos + POS_ONE) == POS_FULL) ? ST_STOPPED : state;
            end else if (step) begin
              pos_nxt   = pos - POS_ONE;
              state_nxt = (pos == POS_ONE) ? ST_STOPPED : state;
            end else begin
              pos_nxt = pos;
            end
          end else if (opp && !opp_blocked) begin
            state_nxt    = ST_SPIN_UP;
            dir_nxt      = ~dir;
            spin_cnt_nxt = {SCW{1'b0}};
          end else begin
            state_nxt = ST_STOPPED;
          end
        end
        ST_FAULT: begin
          if (fault_clr && !UP_M && !DN_M) begin
            state_nxt = ST_STOPPED;
          end else begin
            state_nxt = ST_FAULT;
          end
        end
        default: begin
          state_nxt = ST_STOPPED;
        end
      endcase
    end
  end

  // State and datapath registers; Moving/Fault registered from next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_STOPPED;
      dir      <= DIR_UP;
      spin_cnt <= {SCW{1'b0}};
      pos      <= POS_ZERO;
      moving   <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state    <= state_nxt;
      dir      <= dir_nxt;
      spin_cnt <= spin_cnt_nxt;
      pos      <= pos_nxt;
      moving   <= (state_nxt == ST_RUN_UP) || (state_nxt == ST_RUN_DN);
      fault    <= (state_nxt == ST_FAULT);
    end
  end

  assign Position = pos;
  assign UP_Max   = (pos == POS_FULL);
  assign DN_Max   = (pos == POS_ZERO);
  assign Moving   = moving;
  assign Fault    = fault;

endmodule

// File: tb/tb_garage_door_actuator.sv
// Self-checking bench for garage_door_actuator: directed scenarios plus
// randomized commands compared against a timeline-based reference model.
module tb_garage_door_actuator;

  localparam int FP = 10;
  localparam int SD = 4;
  localparam int MD = 2;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          UP_M = 1'b0;
  logic          DN_M = 1'b0;
  logic          fault_clr = 1'b0;
  logic          UP_Max, DN_Max, Moving, Fault;
  logic [PW-1:0] Position;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: 0 idle, 1 spinning, 2 running, 3 fault.
  int m_mode = 0;
  int m_pos  = 0;
  int m_t    = 0;
  int m_t0   = 0;
  bit m_up   = 1'b1;

  always #5 clk = ~clk;

  garage_door_actuator #(
    .POS_W(PW), .FULL_POS(FP), .STEP_DIV(SD), .MOTOR_DLY(MD)
  ) dut (
    .clk(clk), .rst(rst), .UP_M(UP_M), .DN_M(DN_M), .fault_clr(fault_clr),
    .UP_Max(UP_Max), .DN_Max(DN_Max), .Position(Position),
    .Moving(Moving), .Fault(Fault)
  );

  task automatic model_edge(input bit u, input bit d, input bit c, input bit r);
    bit want, opp, nu;
    m_t++;
    want = m_up ? u : d;
    opp  = m_up ? d : u;
    nu   = !m_up;
    if (!r) begin
      m_mode = 0; m_up = 1'b1; m_pos = 0;
    end else if (m_mode != 3 && u && d) begin
      m_mode = 3;
    end else begin
      case (m_mode)
        0: begin
          if (u && m_pos < FP) begin m_mode = 1; m_up = 1'b1; m_t0 = m_t; end
          else if (d && m_pos > 0) begin m_mode = 1; m_up = 1'b0; m_t0 = m_t; end
        end
        1, 2: begin
          if (want) begin
            if (m_mode == 1 && m_t - m_t0 == MD) begin
              m_mode = 2; m_t0 = m_t;
            end else if (m_mode == 2 && (m_t - m_t0) % SD == 0) begin
              m_pos = m_up ? m_pos + 1 : m_pos - 1;
              if (m_pos == FP || m_pos == 0) m_mode = 0;
            end
          end else if (opp) begin
            if ((nu && m_pos == FP) || (!nu && m_pos == 0)) m_mode = 0;
            else begin m_mode = 1; m_up = nu; m_t0 = m_t; end
          end else begin
            m_mode = 0;
          end
        end
        default: if (c && !u && !d) m_mode = 0;
      endcase
    end
  endtask

  task automatic tick(input bit u, input bit d, input bit c, input bit r);
    UP_M = u; DN_M = d; fault_clr = c; rst = r;
    @(posedge clk);
    model_edge(u, d, c, r);
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    n_tests++; if (Position !== 8'd0) begin n_fail++; $display("FAIL reset_pos got %0d exp 0", Position); end
    n_tests++; if (DN_Max !== 1'b1) begin n_fail++; $display("FAIL reset_dnmax got %b exp 1", DN_Max); end
    n_tests++; if (UP_Max !== 1'b0) begin n_fail++; $display("FAIL reset_upmax got %b exp 0", UP_Max); end
    n_tests++; if (Moving !== 1'b0) begin n_fail++; $display("FAIL reset_moving got %b exp 0", Moving); end
    n_tests++; if (Fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault got %b exp 0", Fault); end
  endtask

  task automatic test_full_open();
    for (int k = 0; k <= MD + FP * SD; k++) begin
      tick(1'b1, 1'b0, 1'b0, 1'b1);
      if (k == 5) begin
        n_tests++; if (Position !== 8'd0) begin n_fail++; $display("FAIL open_e5 got %0d exp 0", Position); end
      end
      if (k == 6) begin
        n_tests++; if (Position !== 8'd1) begin n_fail++; $display("FAIL open_e6 got %0d exp 1", Position); end
      end
      if (k == 41) begin
        n_tests++; if (Moving !== 1'b1) begin n_fail++; $display("FAIL open_e41_moving got %b exp 1", Moving); end
      end
    end
    n_tests++; if (Position !== 8'd10) begin n_fail++; $display("FAIL open_e42_pos got %0d exp 10", Position); end
    n_tests++; if (UP_Max !== 1'b1) begin n_fail++; $display("FAIL open_e42_upmax got %b exp 1", UP_Max); end
    n_tests++; if (Moving !== 1'b0) begin n_fail++; $display("FAIL open_e42_moving got %b exp 0", Moving); end
    n_tests++; if (DN_Max !== 1'b0) begin n_fail++; $display("FAIL open_e42_dnmax got %b exp 0", DN_Max); end
  endtask

  task automatic test_limit_hold();
    for (int k = 0; k < 8; k++) begin
      tick(1'b1, 1'b0, 1'b0, 1'b1);
      n_tests++;
      if (Moving !== 1'b0 || Position !== 8'd10) begin
        n_fail++; $display("FAIL limit_hold moving=%b pos=%0d exp 0/10", Moving, Position);
      end
    end
  endtask

  task automatic test_full_close();
    for (int k = 0; k <= MD + FP * SD; k++) begin
      tick(1'b0, 1'b1, 1'b0, 1'b1);
      if (k == 6) begin
        n_tests++; if (Position !== 8'd9) begin n_fail++; $display("FAIL close_e6 got %0d exp 9", Position); end
      end
    end
    n_tests++; if (Position !== 8'd0) begin n_fail++; $display("FAIL close_e42_pos got %0d exp 0", Position); end
    n_tests++; if (DN_Max !== 1'b1) begin n_fail++; $display("FAIL close_e42_dnmax got %b exp 1", DN_Max); end
    n_tests++; if (Moving !== 1'b0) begin n_fail++; $display("FAIL close_e42_moving got %b exp 0", Moving); end
  endtask

  task automatic run_to(input int target);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 200 && Position != target; i++) tick(1'b1, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (Position !== PW'(target)) begin n_fail++; $display("FAIL run_to got %0d exp %0d", Position, target); end
  endtask

  task automatic test_pause();
    run_to(5);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (Moving !== 1'b0 || Position !== 8'd5) begin
      n_fail++; $display("FAIL pause moving=%b pos=%0d exp 0/5", Moving, Position);
    end
    for (int k = 0; k <= 6; k++) begin
      tick(1'b1, 1'b0, 1'b0, 1'b1);
      if (k == 5) begin
        n_tests++; if (Position !== 8'd5) begin n_fail++; $display("FAIL resume_e5 got %0d exp 5", Position); end
      end
    end
    n_tests++; if (Position !== 8'd6) begin n_fail++; $display("FAIL resume_e6 got %0d exp 6", Position); end
  endtask

  task automatic test_reverse();
    run_to(5);
    for (int k = 0; k <= 6; k++) begin
      tick(1'b0, 1'b1, 1'b0, 1'b1);
      if (k == 0) begin
        n_tests++; if (Moving !== 1'b0) begin n_fail++; $display("FAIL reverse_spin moving got %b exp 0", Moving); end
      end
      if (k == 5) begin
        n_tests++; if (Position !== 8'd5) begin n_fail++; $display("FAIL reverse_e5 got %0d exp 5", Position); end
      end
    end
    n_tests++; if (Position !== 8'd4) begin n_fail++; $display("FAIL reverse_e6 got %0d exp 4", Position); end
  endtask

  task automatic test_fault();
    run_to(3);
    tick(1'b1, 1'b1, 1'b0, 1'b1);
    n_tests++;
    if (Fault !== 1'b1 || Moving !== 1'b0 || Position !== 8'd3) begin
      n_fail++; $display("FAIL fault_enter f=%b m=%b pos=%0d exp 1/0/3", Fault, Moving, Position);
    end
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    n_tests++; if (Fault !== 1'b1) begin n_fail++; $display("FAIL fault_hold got %b exp 1", Fault); end
    tick(1'b0, 1'b1, 1'b1, 1'b1);
    n_tests++; if (Fault !== 1'b1) begin n_fail++; $display("FAIL fault_hold_dn got %b exp 1", Fault); end
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    n_tests++;
    if (Fault !== 1'b0 || Moving !== 1'b0 || Position !== 8'd3) begin
      n_fail++; $display("FAIL fault_clear f=%b m=%b pos=%0d exp 0/0/3", Fault, Moving, Position);
    end
  endtask

  task automatic test_reset_mid();
    run_to(7);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (Position !== 8'd0 || DN_Max !== 1'b1 || Moving !== 1'b0 || UP_Max !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid pos=%0d dn=%b m=%b up=%b exp 0/1/0/0", Position, DN_Max, Moving, UP_Max);
    end
  endtask

  task automatic test_random();
    bit u, d, c, r;
    int sel;
    u = 1'b0; d = 1'b0;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        sel = $urandom_range(0, 99);
        u = (sel < 40) || (sel >= 95);
        d = (sel >= 40 && sel < 80) || (sel >= 95);
      end
      c = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 299) != 0);
      tick(u, d, c, r);
      n_tests++;
      if (Position !== PW'(m_pos) || UP_Max !== (m_pos == FP) || DN_Max !== (m_pos == 0) ||
          Moving !== (m_mode == 2) || Fault !== (m_mode == 3)) begin
        n_fail++;
        $display("FAIL random cyc=%0d pos=%0d up=%b dn=%b mv=%b f=%b exp pos=%0d mode=%0d",
                 i, Position, UP_Max, DN_Max, Moving, Fault, m_pos, m_mode);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_open();
    test_limit_hold();
    test_full_close();
    test_pause();
    test_reverse();
    test_fault();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/garage_door_actuator.md
GARAGE_DOOR_ACTUATOR -- requirements
Module: garage_door_actuator

Interface
REQ-001 SHALL have parameter POS_W, default 8: width of the door position counter.
REQ-002 SHALL have parameter FULL_POS, default 200: position at fully open; position 0 is fully closed.
REQ-003 SHALL have parameter STEP_DIV, default 4: clocks per position step while running; must be 1 or more.
REQ-004 SHALL have parameter MOTOR_DLY, default 2: spin-up clocks before movement; must be 1 or more.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port UP_M, input, 1 bit: motor-up drive command.
REQ-008 SHALL have port DN_M, input, 1 bit: motor-down drive command.
REQ-009 SHALL have port fault_clr, input, 1 bit: fault acknowledge.
REQ-010 SHALL have port UP_Max, output, 1 bit: upper limit switch; high when Position equals FULL_POS.
REQ-011 SHALL have port DN_Max, output, 1 bit: lower limit switch; high when Position equals 0.
REQ-012 SHALL have port Position, output, POS_W bits: current door position, registered.
REQ-013 SHALL have port Moving, output, 1 bit: high in RUN_UP or RUN_DN.
REQ-014 SHALL have port Fault, output, 1 bit: high in the FAULT state.

Function
REQ-015 SHALL implement states STOPPED, SPIN_UP, RUN_UP, RUN_DN and FAULT, plus a direction register dir (up or down).
REQ-016 In STOPPED: UP_M=1, DN_M=0 and Position<FULL_POS -> SPIN_UP with dir=up. DN_M=1, UP_M=0 and Position>0 -> SPIN_UP with dir=down. Otherwise stay in STOPPED; a command toward an already-reached limit is ignored.
REQ-017 In any state other than FAULT, UP_M=1 and DN_M=1 sampled together -> FAULT on that edge; this has the highest priority.
REQ-018 In SPIN_UP: count cycles while the command matching dir is held. On the edge where the count equals MOTOR_DLY-1 -> RUN_UP or RUN_DN, with the prescaler cleared. Command dropped -> STOPPED. Opposite command alone -> restart SPIN_UP with dir flipped and the count cleared.
REQ-019 In RUN_UP/RUN_DN: the prescaler counts 0..STEP_DIV-1. On the terminal count, Position is incremented or decremented by 1 and the prescaler returns to 0.
REQ-020 On the edge where a step makes Position equal FULL_POS (up) or 0 (down), the state SHALL go to STOPPED on that same edge. Position SHALL never exceed FULL_POS and never wrap below 0.
REQ-021 In RUN: command dropped -> STOPPED, Position held, prescaler cleared. Opposite command alone -> SPIN_UP with dir flipped; no step occurs on that edge.
REQ-022 In FAULT: Position held, Moving=0. Exit to STOPPED only when fault_clr=1 and UP_M=0 and DN_M=0 are sampled on the same edge.
REQ-023 Latency: from the first edge sampling a valid command (edge 0), the first step SHALL occur at edge MOTOR_DLY+STEP_DIV. Full travel SHALL complete at edge MOTOR_DLY+FULL_POS*STEP_DIV.
REQ-024 UP_Max and DN_Max SHALL be decoded combinationally from the registered Position only.

Reset
REQ-025 With rst=0 at a clock edge: state=STOPPED, dir=up, Position=0, all counters=0. Resulting outputs: DN_Max=1, UP_Max=0, Moving=0, Fault=0.
REQ-026 Reset asserted mid-travel or in FAULT SHALL override all other behaviour on that edge, returning the door to the closed position.

Structure
REQ-027 Package garage_door_pkg SHALL hold the actuator state encodings (3-bit) and the default values of FULL_POS, STEP_DIV and MOTOR_DLY.
REQ-028 The prescaler SHALL be a single sub-module, door_step_timer, with inputs clk, rst, en and clr and a one-cycle output pulse step. All other logic stays in the top level.

Verification (FULL_POS=10, STEP_DIV=4, MOTOR_DLY=2)
REQ-029 Scenario: after reset, hold UP_M=1 -> Position increments first at edge 6. At edge 42 Position=10, UP_Max=1, Moving=0, DN_Max=0.
REQ-030 Scenario: at Position=10, hold DN_M=1 -> Position reaches 0 at edge 42. DN_Max=1. UP_M=1 while at Position 10 leaves the state at STOPPED.
REQ-031 Scenario: running up at Position=5, drop UP_M -> STOPPED next edge, Position stays 5. Reassert -> the next step occurs 6 edges later.
REQ-032 Scenario: running up at Position=5, switch to DN_M only -> SPIN_UP, then Position=4 at 6 edges after the switch.
REQ-033 Scenario: UP_M=1 and DN_M=1 at Position=3 -> Fault=1 with Position held. fault_clr=1 with commands still high keeps FAULT. fault_clr=1 with both commands low -> STOPPED.
REQ-034 Scenario: rst=0 during RUN_UP at Position=7 -> the next edge gives Position=0, DN_Max=1, Moving=0.
